mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles an access state may persist before the watchdog aborts it.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 n_rst  in  1  synchronous active-high reset; name kept per port convention, 1 = reset.
REQ-005 iREN  in  1  instruction-fetch read request; held until iwait low.
REQ-006 iaddr  in  32  fetch word address; stable while iREN high.
REQ-007 iwait  out  1  fetch stall; low for exactly the completing cycle.
REQ-008 iload  out  32  fetch data; valid when iREN high and iwait low.
REQ-009 dREN, dWEN  in  1 each  data read/write request; held until dwait low.
REQ-010 daddr, dstore  in  32 each  data address and write data; stable while requesting.
REQ-011 dwait  out  1  data stall; dload  out  32  read data, valid when dwait low.
REQ-012 ramREN, ramWEN  out  1 each; ramaddr, ramstore  out  32 each; RAM port drive.
REQ-013 ramload  in  32; ramstate  in  2 (ramstate_t: FREE, BUSY, ACCESS, ERROR).
REQ-014 tmo  out  1  one-cycle pulse when the watchdog aborts an access.

Function
REQ-015 FSM states IDLE, IACC, DACC; registered state, combinational outputs.
REQ-016 IDLE: RAM controls low; if dREQ = dREN|dWEN and iREN both high, grant goes opposite to last_grant flag (round-robin); single request granted directly; next state IACC/DACC.
REQ-017 IACC: ramREN=1, ramWEN=0, ramaddr=iaddr; iload=ramload.
REQ-018 DACC: ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both), ramaddr=daddr, ramstore=dstore; dload=ramload.
REQ-019 Completion = granted state and ramstate==ACCESS; that cycle the granted wait output is 0, all other cycles 1 while its request is high.
REQ-020 A wait output SHALL be 0 whenever its own request is low.
REQ-021 On completion: last_grant <= completing requester; if the other requester is pending, next state is its access state (back-to-back, no IDLE cycle); otherwise IDLE.
REQ-022 Minimum latency: request in IDLE cycle 0, RAM driven cycle 1, earliest wait-low cycle 1.
REQ-023 ramstate BUSY or FREE in an access state: hold state and drive; ERROR: hold and keep re-driving (retry).
REQ-024 Granted requester deasserting its request before completion: RAM controls drop combinationally, next state IDLE, last_grant unchanged.
REQ-025 8-bit watchdog counter cleared on entering an access state, increments each access-state cycle; reaching TIMEOUT-1 without completion: tmo=1 that cycle, wait stays 1, next state IDLE, last_grant <= aborted requester.
REQ-026 iload/dload SHALL be 0 when their requester is not granted.

Reset
REQ-027 n_rst=1 at a clock edge: state IDLE, last_grant = I (data wins first tie), watchdog 0.
REQ-028 During reset and the cycle after: ramREN=ramWEN=0, tmo=0, outputs as IDLE; reset mid-access abandons the access with no completion.

Structure
REQ-029 ramstate_t and the arbiter state enum SHALL live in cpu_types_pkg; TIMEOUT is a module parameter.
REQ-030 Single module; no sub-module.

Verification
REQ-031 iREN only, iaddr=0x40, ramstate ACCESS on 2nd access cycle, ramload=0x2408_0001 -> iwait low once, iload=0x2408_0001, ramREN high 2 cycles.
REQ-032 iREN and dWEN both from reset, daddr=0x100, dstore=0xDEAD_BEEF -> DACC first with ramWEN=1, ramstore=0xDEADBEEF; IACC immediately after completion, no IDLE cycle.
REQ-033 Both requests held continuously, each access 1 cycle -> grants alternate D,I,D,I; neither starves.
REQ-034 dREN=1 at 0x200, ramstate never ACCESS -> tmo pulses at 64th DACC cycle, dwait stays 1, IDLE next, then re-grant.
REQ-035 n_rst=1 during IACC with ramstate BUSY -> next cycle IDLE, ramREN=0, iwait remains 1 while iREN high.
REQ-036 dREN and dWEN both high -> ramWEN=1, ramREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake status and arbiter states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of instruction fetch and data ports onto one RAM,
// with a watchdog that aborts accesses the RAM never completes.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        tmo
);

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    arb_state_t r_state;
    arb_state_t w_next;
    grant_t     r_last;
    grant_t     w_last_next;
    logic [7:0] r_wdog;
    logic       w_dreq;
    logic       w_done;
    logic       w_tmo_hit;

    assign w_dreq    = dREN | dWEN;
    assign w_done    = (ramstate == ACCESS);
    assign w_tmo_hit = (r_wdog == WDOG_LAST);

    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = iREN;
        dwait       = w_dreq;
        iload       = '0;
        dload       = '0;
        tmo         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_dreq && iREN)
                    w_next = (r_last == GRANT_I) ? DACC : IACC;
                else if (w_dreq)
                    w_next = DACC;
                else if (iREN)
                    w_next = IACC;
            end
            IACC: begin
                if (!iREN) begin
                    w_next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    iload   = ramload;
                    if (w_done) begin
                        iwait       = 1'b0;
                        w_last_next = GRANT_I;
                        w_next      = w_dreq ? DACC : IDLE;
                    end else if (w_tmo_hit) begin
                        tmo         = 1'b1;
                        w_last_next = GRANT_I;
                        w_next      = IDLE;
                    end
                end
            end
            DACC: begin
                if (!w_dreq) begin
                    w_next = IDLE;
                end else begin
                    // a simultaneous read+write is treated as a write
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dload    = ramload;
                    if (w_done) begin
                        dwait       = 1'b0;
                        w_last_next = GRANT_D;
                        w_next      = iREN ? IACC : IDLE;
                    end else if (w_tmo_hit) begin
                        tmo         = 1'b1;
                        w_last_next = GRANT_D;
                        w_next      = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        // reset cycle looks like IDLE on every output
        if (n_rst) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
            iload    = '0;
            dload    = '0;
            tmo      = 1'b0;
            iwait    = iREN;
            dwait    = w_dreq;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= IDLE;
            r_last  <= GRANT_I;
            r_wdog  <= '0;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
            if (w_next == IDLE || w_next != r_state)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences,
// and randomized traffic against a request/grant reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TMO = 64;
    localparam logic [31:0] A = 32'h0000_0040;
    localparam logic [31:0] D = 32'h0000_0100;
    localparam logic [31:0] S = 32'hDEAD_BEEF;
    localparam logic [31:0] L = 32'h2408_0001;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    ramstate_t   ramstate = FREE;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .n_rst(n_rst),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .tmo(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst, ir, dr, dw;
        ramstate_t rs;
        logic e_rr, e_rw, e_iw, e_dw;
        logic [31:0] e_addr, e_store, e_il, e_dl;
    } vec_t;

    vec_t tv[17];

    // reference model: who holds the RAM, for how long, who was served last
    int m_owner = 0;
    int m_last  = 1;
    int m_age   = 0;
    logic        e_rr, e_rw, e_iw, e_dw, e_tmo, e_done;
    logic [31:0] e_addr, e_store, e_il, e_dl;

    task automatic model_expect();
        logic dreq;
        dreq = dREN | dWEN;
        e_rr = 0; e_rw = 0; e_addr = 0; e_store = 0;
        e_il = 0; e_dl = 0; e_tmo = 0; e_done = 0;
        e_iw = iREN; e_dw = dreq;
        if (n_rst) return;
        if (m_owner == 1 && iREN) begin
            e_rr = 1; e_addr = iaddr; e_il = ramload;
            if (ramstate == ACCESS) begin
                e_iw = 0; e_done = 1;
            end else if (m_age == TMO - 1) e_tmo = 1;
        end else if (m_owner == 2 && dreq) begin
            e_rw = dWEN; e_rr = dREN && !dWEN;
            e_addr = daddr; e_store = dstore; e_dl = ramload;
            if (ramstate == ACCESS) begin
                e_dw = 0; e_done = 1;
            end else if (m_age == TMO - 1) e_tmo = 1;
        end
    endtask

    task automatic model_step();
        logic dreq;
        bit   want_i, want_d;
        dreq = dREN | dWEN;
        want_i = iREN;
        want_d = dreq;
        if (n_rst) begin
            m_owner = 0; m_last = 1; m_age = 0;
        end else if (m_owner == 0) begin
            m_age = 0;
            if (want_i && want_d) m_owner = (m_last == 1) ? 2 : 1;
            else if (want_d) m_owner = 2;
            else if (want_i) m_owner = 1;
        end else if ((m_owner == 1 && !want_i) ||
                     (m_owner == 2 && !want_d)) begin
            m_owner = 0;
        end else if (e_done) begin
            m_last = m_owner;
            m_age = 0;
            if (m_owner == 1) m_owner = want_d ? 2 : 0;
            else m_owner = want_i ? 1 : 0;
        end else if (e_tmo) begin
            m_last = m_owner;
            m_owner = 0;
            m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    initial begin
        int ren_cnt, iw_low, tmo_cnt, tmo_at, dw_low;

        tv[0]  = '{1'b1,1'b1,1'b0,1'b1,ACCESS, 1'b0,1'b0,1'b1,1'b1, 0,0,0,0};
        tv[1]  = '{1'b0,1'b1,1'b0,1'b1,ACCESS, 1'b0,1'b0,1'b1,1'b1, 0,0,0,0};
        tv[2]  = '{1'b0,1'b1,1'b0,1'b1,ACCESS, 1'b0,1'b1,1'b1,1'b0, D,S,0,L};
        tv[3]  = '{1'b0,1'b1,1'b0,1'b0,BUSY,   1'b1,1'b0,1'b1,1'b0, A,0,L,0};
        tv[4]  = '{1'b0,1'b1,1'b0,1'b0,ACCESS, 1'b1,1'b0,1'b0,1'b0, A,0,L,0};
        tv[5]  = '{1'b0,1'b0,1'b1,1'b1,ACCESS, 1'b0,1'b0,1'b0,1'b1, 0,0,0,0};
        tv[6]  = '{1'b0,1'b0,1'b1,1'b1,ACCESS, 1'b0,1'b1,1'b0,1'b0, D,S,0,L};
        tv[7]  = '{1'b0,1'b1,1'b1,1'b0,ACCESS, 1'b0,1'b0,1'b1,1'b1, 0,0,0,0};
        tv[8]  = '{1'b0,1'b1,1'b1,1'b0,ACCESS, 1'b1,1'b0,1'b0,1'b1, A,0,L,0};
        tv[9]  = '{1'b0,1'b1,1'b1,1'b0,ACCESS, 1'b1,1'b0,1'b1,1'b0, D,S,0,L};
        tv[10] = '{1'b0,1'b1,1'b1,1'b0,ACCESS, 1'b1,1'b0,1'b0,1'b1, A,0,L,0};
        tv[11] = '{1'b0,1'b1,1'b1,1'b0,ACCESS, 1'b1,1'b0,1'b1,1'b0, D,S,0,L};
        tv[12] = '{1'b1,1'b1,1'b0,1'b0,BUSY,   1'b0,1'b0,1'b1,1'b0, 0,0,0,0};
        tv[13] = '{1'b0,1'b1,1'b0,1'b0,BUSY,   1'b0,1'b0,1'b1,1'b0, 0,0,0,0};
        tv[14] = '{1'b0,1'b1,1'b0,1'b0,BUSY,   1'b1,1'b0,1'b1,1'b0, A,0,L,0};
        tv[15] = '{1'b0,1'b0,1'b0,1'b0,BUSY,   1'b0,1'b0,1'b0,1'b0, 0,0,0,0};
        tv[16] = '{1'b0,1'b0,1'b0,1'b0,BUSY,   1'b0,1'b0,1'b0,1'b0, 0,0,0,0};

        tick();
        iaddr = A; daddr = D; dstore = S; ramload = L;
        for (int k = 0; k < 17; k++) begin
            n_rst = tv[k].rst; iREN = tv[k].ir;
            dREN = tv[k].dr; dWEN = tv[k].dw; ramstate = tv[k].rs;
            @(negedge clk);
            chk1($sformatf("v%0d ramREN", k), ramREN, tv[k].e_rr);
            chk1($sformatf("v%0d ramWEN", k), ramWEN, tv[k].e_rw);
            chk1($sformatf("v%0d iwait", k), iwait, tv[k].e_iw);
            chk1($sformatf("v%0d dwait", k), dwait, tv[k].e_dw);
            chk1($sformatf("v%0d tmo", k), tmo, 1'b0);
            chk($sformatf("v%0d ramaddr", k), ramaddr, tv[k].e_addr);
            chk($sformatf("v%0d ramstore", k), ramstore, tv[k].e_store);
            chk($sformatf("v%0d iload", k), iload, tv[k].e_il);
            chk($sformatf("v%0d dload", k), dload, tv[k].e_dl);
            tick();
        end

        // fetch alone, RAM answers on the second access cycle
        n_rst = 1; iREN = 0; dREN = 0; dWEN = 0;
        tick();
        n_rst = 0; iREN = 1; iaddr = A;
        ren_cnt = 0; iw_low = 0;
        for (int c = 0; c < 4; c++) begin
            ramstate = (c == 2) ? ACCESS : BUSY;
            @(negedge clk);
            if (ramREN) ren_cnt++;
            if (iREN && !iwait) begin
                iw_low++;
                chk("fetch iload", iload, L);
                chk("fetch cycle", c, 2);
            end
            tick();
            if (c == 2) iREN = 0;
        end
        chk("fetch ramREN cycles", ren_cnt, 2);
        chk("fetch iwait lows", iw_low, 1);

        // data read the RAM never completes: watchdog abort then re-grant
        n_rst = 1; tick();
        n_rst = 0; dREN = 1; daddr = 32'h200; ramstate = BUSY;
        tmo_cnt = 0; tmo_at = -1; dw_low = 0;
        for (int c = 0; c < 67; c++) begin
            @(negedge clk);
            if (tmo) begin tmo_cnt++; tmo_at = c; end
            if (!dwait) dw_low++;
            if (c == 65) chk1("post-tmo ramREN", ramREN, 1'b0);
            if (c == 66) begin
                chk1("regrant ramREN", ramREN, 1'b1);
                chk("regrant ramaddr", ramaddr, 32'h200);
            end
            tick();
        end
        chk("tmo pulses", tmo_cnt, 1);
        chk("tmo cycle", tmo_at, 64);
        chk("dwait lows", dw_low, 0);

        // randomized traffic against the model
        n_rst = 1; model_expect();
        @(posedge clk); model_step(); #1;
        for (int c = 0; c < 3000; c++) begin
            n_rst = ($urandom_range(0, 99) < 2);
            iREN = ($urandom_range(0, 9) < 7);
            dREN = ($urandom_range(0, 9) < 5);
            dWEN = ($urandom_range(0, 9) < 4);
            iaddr = $urandom; daddr = $urandom;
            dstore = $urandom; ramload = $urandom;
            ramstate = ramstate_t'($urandom_range(0, 3));
            @(negedge clk);
            model_expect();
            chk1("rnd ramREN", ramREN, e_rr);
            chk1("rnd ramWEN", ramWEN, e_rw);
            chk1("rnd iwait", iwait, e_iw);
            chk1("rnd dwait", dwait, e_dw);
            chk1("rnd tmo", tmo, e_tmo);
            chk("rnd ramaddr", ramaddr, e_addr);
            chk("rnd ramstore", ramstore, e_store);
            chk("rnd iload", iload, e_il);
            chk("rnd dload", dload, e_dl);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
